uart_prog_loader: RTL and testbench

Parametrised program loader. It sits between the UART receiver and the CPU's instruction memory, and supersedes the fixed 16-bit load FSM inside the single-cycle CPU top. It assembles a byte stream (count, words, checksum) into WORD_W-bit words and writes them to consecutive instruction-memory addresses. It also adds bounds checking, XOR checksum verification, an inter-byte timeout, and an explicit run/hold handshake that gates the CPU core.

---
 rtl/uart_prog_loader.sv | 219 +++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Program loader: assembles a UART byte frame (count, words, XOR checksum) into instruction-memory writes.
// Latency: mem_we one cycle after a word's last byte; status outputs one cycle after the deciding event.
// Backpressure: none; accepts one byte per cycle back-to-back, bytes outside loading states are dropped.
//
// Ports:
//   CLK, RESET             clock, asynchronous active-low reset
//   reload_n               synchronous active-low abort/restart (wins over a simultaneous byte)
//   run_req                start pulse from DONE when AUTO_RUN=0
//   rx_byte, rx_valid      byte stream from uart_rx
//   mem_we/addr/wdata      instruction-memory write port, one strobe per assembled word
//   cpu_hold, cpu_run      CPU reset gate and run enable
//   loading, load_err      frame in progress / sticky error
//   words_loaded           words written in the current frame
module uart_prog_loader #(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int AUTO_RUN    = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              reload_n,
  input  logic              run_req,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_run,
  output logic              loading,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int BPW   = WORD_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
  // Compared against the counter before it increments, so the error
  // lands exactly TIMEOUT_CYC edges after the last accepted byte.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]      DEPTH_L  = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_COUNT_L,
    S_COUNT_H,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_RUN,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        cnt_lo;
  logic [15:0]       n_words;
  logic [7:0]        xor_acc;
  logic [IDX_W-1:0]  byte_idx;
  logic [WORD_W-1:0] wbuf;
  logic [ADDR_W-1:0] addr;
  logic [TO_W-1:0]   to_cnt;

  logic [15:0]       n_rx;
  logic [15:0]       wl_inc;
  logic [WORD_W-1:0] word_ins;
  logic              word_done;
  logic              timed_out;
  logic              in_frame;

  assign n_rx      = {rx_byte, cnt_lo};
  assign wl_inc    = words_loaded + 16'd1;
  assign timed_out = (to_cnt == TO_LAST);
  assign in_frame  = (state == S_COUNT_H) || (state == S_DATA) || (state == S_CSUM);

  // Word buffer with the incoming byte merged in, so the final byte of a
  // word goes straight to mem_wdata without an extra cycle.
  always_comb begin
    word_ins = wbuf;
    for (int k = 0; k < BPW; k++) begin
      if (byte_idx == IDX_W'(k)) begin
        word_ins[8*k +: 8] = rx_byte;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_COUNT_L;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_done = 1'b0;
    if (!reload_n) begin
      state_nxt = S_COUNT_L;
    end else begin
      case (state)
        S_COUNT_L: begin
          if (rx_valid) state_nxt = S_COUNT_H;
        end
        S_COUNT_H: begin
          if (rx_valid) begin
            if ({1'b0, n_rx} > DEPTH_L) state_nxt = S_ERR;
            else if (n_rx == 16'd0)     state_nxt = S_CSUM;
            else                        state_nxt = S_DATA;
          end else if (timed_out) begin
            state_nxt = S_ERR;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            if (byte_idx == LAST_IDX) begin
              word_done = 1'b1;
              if (wl_inc == n_words) state_nxt = S_CSUM;
            end
          end else if (timed_out) begin
            state_nxt = S_ERR;
          end
        end
        S_CSUM: begin
          if (rx_valid) begin
            state_nxt = (rx_byte == xor_acc) ? S_DONE : S_ERR;
          end else if (timed_out) begin
            state_nxt = S_ERR;
          end
        end
        S_DONE: begin
          if ((AUTO_RUN != 0) || run_req) state_nxt = S_RUN;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_lo       <= '0;
      n_words      <= '0;
      xor_acc      <= '0;
      byte_idx     <= '0;
      wbuf         <= '0;
      addr         <= '0;
      to_cnt       <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cpu_hold     <= 1'b1;
      cpu_run      <= 1'b0;
      loading      <= 1'b1;
      load_err     <= 1'b0;
    end else begin
      // Status flags are decoded from the next state so they change on
      // the same edge as the state itself.
      mem_we   <= word_done;
      cpu_hold <= !((state_nxt == S_DONE) || (state_nxt == S_RUN));
      cpu_run  <= (state_nxt == S_RUN);
      loading  <= (state_nxt == S_COUNT_L) || (state_nxt == S_COUNT_H) ||
                  (state_nxt == S_DATA)    || (state_nxt == S_CSUM);
      load_err <= (state_nxt == S_ERR);

      if (!reload_n) begin
        xor_acc      <= '0;
        byte_idx     <= '0;
        addr         <= '0;
        words_loaded <= '0;
        to_cnt       <= '0;
      end else begin
        if (rx_valid && ((state == S_COUNT_L) || (state == S_COUNT_H) || (state == S_DATA))) begin
          xor_acc <= xor_acc ^ rx_byte;
        end

        if (rx_valid || !in_frame) begin
          to_cnt <= '0;
        end else if (!timed_out) begin
          to_cnt <= to_cnt + 1'b1;
        end

        if (rx_valid) begin
          case (state)
            S_COUNT_L: begin
              cnt_lo <= rx_byte;
            end
            S_COUNT_H: begin
              n_words  <= n_rx;
              byte_idx <= '0;
              addr     <= '0;
            end
            S_DATA: begin
              wbuf <= word_ins;
              if (word_done) begin
                mem_addr     <= addr;
                mem_wdata    <= word_ins;
                addr         <= addr + 1'b1;
                words_loaded <= wl_inc;
                byte_idx     <= '0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end
            default: begin
              cnt_lo <= cnt_lo;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: instance A (16-bit words, auto run) and
// instance B (32-bit words, run on request), both with a 100-cycle timeout.
// A frame-level model predicts every output each cycle; literal checks pin it.
module tb_uart_prog_loader;

  localparam int LD = 0, DN = 1, RN = 2, ER = 3;
  localparam int TO = 100;
  localparam int DEP = 256;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET;
  logic       reload_n, run_req, rx_valid;
  logic [7:0] rx_byte;
  int         tgt;

  logic rxv_a, rxv_b, rld_a, rld_b, rrq_a, rrq_b;
  assign rxv_a = rx_valid && (tgt == 0);
  assign rxv_b = rx_valid && (tgt == 1);
  assign rld_a = reload_n || (tgt != 0);
  assign rld_b = reload_n || (tgt != 1);
  assign rrq_a = run_req && (tgt == 0);
  assign rrq_b = run_req && (tgt == 1);

  logic        we_a, hold_a, run_a, load_a, err_a;
  logic [15:0] addr_a, wdata_a, wl_a;
  logic        we_b, hold_b, run_b, load_b, err_b;
  logic [15:0] addr_b, wl_b;
  logic [31:0] wdata_b;

  uart_prog_loader #(.WORD_W(16), .ADDR_W(16), .DEPTH(DEP), .TIMEOUT_CYC(TO), .AUTO_RUN(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .reload_n(rld_a), .run_req(rrq_a),
    .rx_byte(rx_byte), .rx_valid(rxv_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .cpu_hold(hold_a), .cpu_run(run_a), .loading(load_a), .load_err(err_a),
    .words_loaded(wl_a)
  );

  uart_prog_loader #(.WORD_W(32), .ADDR_W(16), .DEPTH(DEP), .TIMEOUT_CYC(TO), .AUTO_RUN(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .reload_n(rld_b), .run_req(rrq_b),
    .rx_byte(rx_byte), .rx_valid(rxv_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .cpu_hold(hold_b), .cpu_run(run_b), .loading(load_b), .load_err(err_b),
    .words_loaded(wl_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int          st[2];
  int          fs[2];
  int          idle[2];
  int          wl[2];
  bit          m_we[2];
  int          m_addr[2];
  logic [31:0] m_data[2];
  logic [7:0]  fb[2][0:1199];

  function automatic int bpw(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic bit auto_run(input int d);
    return (d == 0);
  endfunction

  task automatic model_reset(input int d);
    st[d] = LD; fs[d] = 0; idle[d] = 0; wl[d] = 0; m_we[d] = 0;
  endtask

  task automatic model_step(input int d, input bit v, input logic [7:0] b, input bit rl, input bit rr);
    int s, n, k, bp;
    logic [31:0] data;
    logic [7:0]  x;
    m_we[d] = 0;
    bp = bpw(d);
    if (!rl) begin
      model_reset(d);
      return;
    end
    case (st[d])
      LD: begin
        if (v) begin
          idle[d] = 0;
          fb[d][fs[d]] = b;
          fs[d]++;
          s = fs[d];
          n = 0;
          if (s >= 2) n = int'({fb[d][1], fb[d][0]});
          if (s == 2) begin
            if (n > DEP) st[d] = ER;
          end else if (s > 2 && s <= 2 + n * bp) begin
            if ((s - 2) % bp == 0) begin
              k = (s - 2) / bp - 1;
              data = 0;
              for (int j = 0; j < bp; j++) data |= 32'(fb[d][2 + k * bp + j]) << (8 * j);
              m_we[d] = 1; m_addr[d] = k; m_data[d] = data; wl[d] = k + 1;
            end
          end else if (s == 3 + n * bp) begin
            x = 0;
            for (int i = 0; i < s - 1; i++) x ^= fb[d][i];
            st[d] = (x == b) ? DN : ER;
          end
        end else if (fs[d] >= 1) begin
          idle[d]++;
          if (idle[d] == TO) st[d] = ER;
        end
      end
      DN: if (auto_run(d) || rr) st[d] = RN;
      default: ;
    endcase
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, rxv_a, rx_byte, rld_a, rrq_a);
      model_step(1, rxv_b, rx_byte, rld_b, rrq_b);
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_dut(input int d, input logic we, input logic [15:0] ad, input logic [31:0] wd,
                         input logic hold, input logic run, input logic ld, input logic er,
                         input logic [15:0] w);
    string p;
    p = (d == 0) ? "A." : "B.";
    chk({p, "mem_we"}, 32'(we), 32'(m_we[d]));
    if (m_we[d]) begin
      chk({p, "mem_addr"}, 32'(ad), 32'(m_addr[d]));
      chk({p, "mem_wdata"}, wd, m_data[d]);
    end
    chk({p, "cpu_hold"}, 32'(hold), 32'(st[d] != DN && st[d] != RN));
    chk({p, "cpu_run"}, 32'(run), 32'(st[d] == RN));
    chk({p, "loading"}, 32'(ld), 32'(st[d] == LD));
    chk({p, "load_err"}, 32'(er), 32'(st[d] == ER));
    chk({p, "words_loaded"}, 32'(w), 32'(wl[d]));
  endtask

  logic [15:0] la_addr[$];
  logic [15:0] la_data[$];
  logic [31:0] lb_data[$];
  logic [15:0] lb_addr[$];

  always @(negedge CLK) begin
    cmp_dut(0, we_a, addr_a, 32'(wdata_a), hold_a, run_a, load_a, err_a, wl_a);
    cmp_dut(1, we_b, addr_b, wdata_b, hold_b, run_b, load_b, err_b, wl_b);
    if (we_a === 1'b1) begin la_addr.push_back(addr_a); la_data.push_back(wdata_a); end
    if (we_b === 1'b1) begin lb_addr.push_back(addr_b); lb_data.push_back(wdata_b); end
  end

  // ---------------- stimulus ----------------
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge CLK);
      rx_valid = 0; run_req = 0; reload_n = 1;
    end
  endtask

  task automatic sg(input logic [7:0] b, input int g);
    @(negedge CLK);
    rx_byte = b; rx_valid = 1; run_req = 0; reload_n = 1;
    gap(g);
  endtask

  task automatic pulse_reload();
    @(negedge CLK);
    rx_valid = 0; reload_n = 0;
    gap(1);
  endtask

  task automatic pulse_run();
    @(negedge CLK);
    rx_valid = 0; run_req = 1;
    gap(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 0; reload_n = 1; run_req = 0; rx_valid = 0; rx_byte = 0; tgt = 0;
    @(negedge CLK);
    chk("rst.hold", 32'(hold_a), 32'd1);
    chk("rst.run", 32'(run_a), 32'd0);
    chk("rst.loading", 32'(load_a), 32'd1);
    chk("rst.err", 32'(err_a), 32'd0);
    chk("rst.we", 32'(we_a), 32'd0);
    chk("rst.addr", 32'(addr_a), 32'd0);
    chk("rst.wdata", 32'(wdata_b), 32'd0);
    chk("rst.wl", 32'(wl_b), 32'd0);
    @(negedge CLK);
    RESET = 1;
    gap(2);

    // A: good 16-bit frame, spaced bytes
    sg(8'h02, 2); sg(8'h00, 2); sg(8'h34, 2); sg(8'h12, 2);
    sg(8'hCD, 2); sg(8'hAB, 2); sg(8'h42, 0);
    gap(3);
    chk("good.nwrites", 32'(la_data.size()), 32'd2);
    chk("good.addr0", 32'(la_addr[0]), 32'd0);
    chk("good.data0", 32'(la_data[0]), 32'h1234);
    chk("good.addr1", 32'(la_addr[1]), 32'd1);
    chk("good.data1", 32'(la_data[1]), 32'hABCD);
    chk("good.wl", 32'(wl_a), 32'd2);
    chk("good.run", 32'(run_a), 32'd1);
    chk("good.hold", 32'(hold_a), 32'd0);
    pulse_reload();
    chk("rld.loading", 32'(load_a), 32'd1);
    chk("rld.run", 32'(run_a), 32'd0);
    chk("rld.wl", 32'(wl_a), 32'd0);

    // A: bad checksum, back-to-back bytes
    sg(8'h02, 0); sg(8'h00, 0); sg(8'h34, 0); sg(8'h12, 0);
    sg(8'hCD, 0); sg(8'hAB, 0); sg(8'h43, 0);
    gap(3);
    chk("badcs.nwrites", 32'(la_data.size()), 32'd4);
    chk("badcs.err", 32'(err_a), 32'd1);
    chk("badcs.hold", 32'(hold_a), 32'd1);
    chk("badcs.run", 32'(run_a), 32'd0);
    pulse_reload();
    chk("badcs.rld.err", 32'(err_a), 32'd0);
    chk("badcs.rld.loading", 32'(load_a), 32'd1);

    // A: count over DEPTH
    sg(8'h01, 1); sg(8'h01, 0);
    gap(1);
    chk("big.err", 32'(err_a), 32'd1);
    gap(3);
    chk("big.nwrites", 32'(la_data.size()), 32'd4);
    pulse_reload();

    // A: inter-byte timeout
    sg(8'h03, 1); sg(8'h00, 1); sg(8'h11, 1);
    repeat (99) @(negedge CLK);
    chk("to.before", 32'(err_a), 32'd0);
    @(negedge CLK);
    chk("to.at", 32'(err_a), 32'd1);
    chk("to.wl", 32'(wl_a), 32'd0);
    pulse_reload();

    // A: asynchronous reset mid-frame
    sg(8'h02, 0); sg(8'h00, 0); sg(8'h34, 0); sg(8'h12, 2);
    chk("arst.pre.wl", 32'(wl_a), 32'd1);
    #2 RESET = 0;
    #1;
    chk("arst.wl", 32'(wl_a), 32'd0);
    chk("arst.loading", 32'(load_a), 32'd1);
    chk("arst.hold", 32'(hold_a), 32'd1);
    @(negedge CLK);
    RESET = 1;
    gap(2);

    // B: 32-bit frame, spaced then back-to-back
    tgt = 1;
    gap(1);
    sg(8'h01, 2); sg(8'h00, 2); sg(8'h78, 2); sg(8'h56, 2);
    sg(8'h34, 2); sg(8'h12, 2); sg(8'h09, 0);
    gap(3);
    chk("w32.nwrites", 32'(lb_data.size()), 32'd1);
    chk("w32.data", lb_data[0], 32'h12345678);
    chk("w32.addr", 32'(lb_addr[0]), 32'd0);
    chk("w32.hold", 32'(hold_b), 32'd0);
    chk("w32.run", 32'(run_b), 32'd0);
    pulse_run();
    chk("w32.runreq", 32'(run_b), 32'd1);
    pulse_reload();
    sg(8'h01, 0); sg(8'h00, 0); sg(8'h78, 0); sg(8'h56, 0);
    sg(8'h34, 0); sg(8'h12, 0); sg(8'h09, 0);
    gap(3);
    chk("w32b2b.data", lb_data[1], 32'h12345678);
    chk("w32b2b.hold", 32'(hold_b), 32'd0);
    pulse_reload();

    // B: empty frame, manual run, reload with a colliding byte
    sg(8'h00, 0); sg(8'h00, 0); sg(8'h00, 0);
    gap(4);
    chk("empty.hold", 32'(hold_b), 32'd0);
    chk("empty.run", 32'(run_b), 32'd0);
    pulse_run();
    chk("empty.runreq", 32'(run_b), 32'd1);
    @(negedge CLK);
    rx_byte = 8'h05; rx_valid = 1; reload_n = 0;
    gap(1);
    chk("drop.loading", 32'(load_b), 32'd1);
    chk("drop.run", 32'(run_b), 32'd0);
    sg(8'h01, 0); sg(8'h00, 0); sg(8'hAA, 0); sg(8'hBB, 0);
    sg(8'hCC, 0); sg(8'hDD, 0); sg(8'h01, 0);
    gap(3);
    chk("drop.nwrites", 32'(lb_data.size()), 32'd3);
    chk("drop.data", lb_data[lb_data.size() - 1], 32'hDDCCBBAA);
    chk("drop.hold", 32'(hold_b), 32'd0);
    gap(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
